pz_shadow_ctrl: RTL and testbench
=================================

# pz_shadow_ctrl

Frame-synchronous configuration controller for the pole/zero datapath. Captures the AXI-Lite register file into a back buffer when software commits, then swaps it into the active set only at start-of-frame. The per-pole subtract, atan and log-magnitude lanes and both `pz_accumulator` instances therefore see one coherent pole/zero set and count for a whole frame. Sits between `data_mem` and the per-pole generate loop; replaces the hardwired `no_z`/`no_p` constants.

## Interface
- `REG_FILE_SIZE`, 16: total 32-bit words in `regfile_flat`. Words 0..REG_FILE_SIZE-2 are pole/zero values; the last word is control.
- `NPZ`, REG_FILE_SIZE-1: number of pole/zero slots (derived, not overridden).

Ports:
- `out_stream_aclk`  in  1  sole clock. `regfile_flat` is produced in this same clock domain.
- `periph_resetn`  in  1  asynchronous, active-low reset.
- `regfile_flat`  in  32*REG_FILE_SIZE  live register file from `data_mem`.
- `frame_start`  in  1  one-cycle pulse, first pixel of a frame accepted (`first & valid & ready`).
- `pz_flat`  out  32*NPZ  active pole/zero words, slot i at `[i*32 +: 32]`; re in [31:16], im in [15:0].
- `no_z`  out  32  active zero count, clamped.
- `no_p`  out  32  active pole count, clamped.
- `cfg_valid`  out  1  high once the first swap has occurred.
- `status`  out  32  readback: [31] ack toggle, [17:16] state, [15:8] swap_count, [7:0] copy index.

## Operation
- Control word fields: [7:0] req_z, [15:8] req_p, [31] commit toggle.
- Commit detection: a registered copy `last_tog` of bit 31. A commit is detected when bit31 != last_tog. `last_tog` resets to 0, so bit31 = 1 at reset release is treated as a commit.
- FSM states: IDLE=0, COPY=1, READY=2.
  - IDLE: on commit, go to COPY and set idx = 0.
  - COPY: each cycle writes `back[idx] <= word[idx]` and increments idx. At idx == NPZ-1, write that word, latch clamped counts into the back registers, and go to READY.
  - READY: hold until `frame_start`. On `frame_start`: `active <= back`, active counts <= back counts, toggle ack bit, increment swap_count (8-bit, wraps 255->0), set `cfg_valid`, return to IDLE.
- Commit during COPY or READY: restart COPY at idx 0. The back buffer is discarded.
- Commit and `frame_start` in the same cycle while in READY: the swap executes with the current back buffer, then the FSM goes to COPY at idx 0 for the new commit.
- `frame_start` in IDLE or COPY: ignored. The active set is unchanged.
- Clamping: `no_z = min(req_z, NPZ)` and `no_p = min(req_p, NPZ - no_z)`, computed at the last COPY cycle. Outputs are zero-extended to 32 bits.

## Timing
- Reset (asynchronous): state IDLE, idx 0, `last_tog` 0, back and active buffers all 0, `no_z`/`no_p` 0, `cfg_valid` 0, `status` 0.
- Commit latency: toggle visible at edge t means COPY is entered at t+1, words 0..NPZ-1 are written at t+1..t+NPZ, and READY is entered at t+NPZ+1. With the default this is 15 copy cycles, READY at t+16.
- Swap: on the edge where `frame_start` = 1 in READY, outputs change. They are valid from the next cycle, which is the first cycle after the frame's first pixel handshake, for that whole frame.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- No handshake back-pressure: software polls `status[31]` against its own toggle to see completion.

## Structure
- Shared package `pz_pkg`:
  - CTRL field offsets (Z_LSB=0, P_LSB=8, TOG_BIT=31)
  - state encoding constants
  - STATUS field offsets, reused by the `data_mem` readback path.
- No sub-module. Edge detect, copy counter and clamp live inline; the block is about 150-250 lines.

## Test plan
- Reset, then inspect outputs: all outputs 0, state IDLE. Hold bit31 = 0 and pulse `frame_start`: nothing changes.
- Write slot 0 = 0x0010_FFF0, control = 0x8000_0203, wait 20 cycles, pulse `frame_start`: next cycle `pz_flat[31:0]` = 0x0010_FFF0, `no_z` = 3, `no_p` = 2, `cfg_valid` = 1, swap_count = 1, `status[31]` = 1.
- Control req_z = 20, req_p = 9: after swap, `no_z` = 15 and `no_p` = 0. Then req_z = 10, req_p = 9: `no_z` = 10 and `no_p` = 5.
- Pulse `frame_start` at cycle 8 of COPY: no swap. A later `frame_start` in READY swaps.
- Toggle commit again at COPY idx 7: idx restarts at 0 and READY is entered 15 cycles after the restart. Toggle again in the same cycle as `frame_start` in READY: the swap occurs and state goes to COPY.
- Assert reset mid-COPY: all outputs return to 0 immediately. After release with bit31 still 1, a new COPY starts.

Source files
------------

// File: rtl/pz_pkg.sv
// pz_pkg: shared field offsets, state encoding and count clamp for the pole/zero config path
package pz_pkg;
    localparam int Z_LSB   = 0;
    localparam int P_LSB   = 8;
    localparam int TOG_BIT = 31;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COPY  = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;

    localparam int STAT_IDX_LSB   = 0;
    localparam int STAT_SWAP_LSB  = 8;
    localparam int STAT_STATE_LSB = 16;
    localparam int STAT_ACK_BIT   = 31;

    // Zeros take priority; poles get whatever slots remain. Returns {no_p, no_z}.
    function automatic logic [15:0] pz_clamp(input logic [7:0] req_z, input logic [7:0] req_p,
                                             input logic [7:0] npz);
        logic [7:0] nz;
        logic [7:0] room;
        nz   = (req_z > npz) ? npz : req_z;
        room = npz - nz;
        return {((req_p > room) ? room : req_p), nz};
    endfunction
endpackage

// File: rtl/pz_shadow_ctrl_if.sv
// pz_shadow_ctrl_if: register-file input, frame pulse and active configuration outputs
interface pz_shadow_ctrl_if #(
    parameter int REG_FILE_SIZE = 16
);
    localparam int NPZ = REG_FILE_SIZE - 1;

    logic [32*REG_FILE_SIZE-1:0] regfile_flat;
    logic                        frame_start;
    logic [32*NPZ-1:0]           pz_flat;
    logic [31:0]                 no_z;
    logic [31:0]                 no_p;
    logic                        cfg_valid;
    logic [31:0]                 status;

    modport master (
        output regfile_flat, frame_start,
        input  pz_flat, no_z, no_p, cfg_valid, status
    );

    modport slave (
        input  regfile_flat, frame_start,
        output pz_flat, no_z, no_p, cfg_valid, status
    );
endinterface

// File: rtl/pz_shadow_ctrl.sv
// pz_shadow_ctrl: captures the register file on commit, swaps it in at start-of-frame
module pz_shadow_ctrl
    import pz_pkg::*;
#(
    parameter int REG_FILE_SIZE = 16
) (
    input  logic            out_stream_aclk,
    input  logic            periph_resetn,
    pz_shadow_ctrl_if.slave bus
);
    localparam int NPZ = REG_FILE_SIZE - 1;
    localparam int IW  = $clog2(NPZ);
    localparam int CB  = NPZ * 32;

    logic [1:0]    r_state;
    logic [IW-1:0] r_idx;
    logic          r_last_tog;
    logic          r_ack;
    logic          r_cfg_valid;
    logic [7:0]    r_swap_cnt;
    logic [7:0]    r_back_z;
    logic [7:0]    r_back_p;
    logic [7:0]    r_nz;
    logic [7:0]    r_np;
    logic [31:0]   r_back   [NPZ];
    logic [31:0]   r_active [NPZ];

    logic [31:0]   w_word   [NPZ];
    logic [7:0]    w_req_z;
    logic [7:0]    w_req_p;
    logic [15:0]   w_clamp;
    logic          w_tog;
    logic          w_commit;
    logic          w_swap;
    logic          w_last;
    logic [31:0]   w_status;

    assign w_req_z  = bus.regfile_flat[CB + Z_LSB +: 8];
    assign w_req_p  = bus.regfile_flat[CB + P_LSB +: 8];
    assign w_tog    = bus.regfile_flat[CB + TOG_BIT];
    assign w_commit = w_tog ^ r_last_tog;
    assign w_swap   = (r_state == S_READY) && bus.frame_start;
    assign w_last   = (r_state == S_COPY) && (r_idx == IW'(NPZ - 1));
    assign w_clamp  = pz_clamp(w_req_z, w_req_p, 8'(NPZ));

    genvar g;
    generate
        for (g = 0; g < NPZ; g++) begin : g_slot
            assign w_word[g] = bus.regfile_flat[g*32 +: 32];
            assign bus.pz_flat[g*32 +: 32] = r_active[g];
        end
    endgenerate

    // Commit detect, one-word-per-cycle copy into back buffer, then swap on frame start
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_last_tog  <= 1'b0;
            r_ack       <= 1'b0;
            r_cfg_valid <= 1'b0;
            r_swap_cnt  <= '0;
            r_back_z    <= '0;
            r_back_p    <= '0;
            r_nz        <= '0;
            r_np        <= '0;
            for (int i = 0; i < NPZ; i++) begin
                r_back[i]   <= '0;
                r_active[i] <= '0;
            end
        end else begin
            r_last_tog <= w_tog;
            if (w_commit) begin
                r_state <= S_COPY;
                r_idx   <= '0;
            end else if (r_state == S_COPY) begin
                r_back[r_idx] <= w_word[r_idx];
                if (w_last) begin
                    r_state  <= S_READY;
                    r_back_z <= w_clamp[7:0];
                    r_back_p <= w_clamp[15:8];
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end else if (w_swap) begin
                r_state <= S_IDLE;
            end
            if (w_swap) begin
                r_active    <= r_back;
                r_nz        <= r_back_z;
                r_np        <= r_back_p;
                r_ack       <= ~r_ack;
                r_swap_cnt  <= r_swap_cnt + 1'b1;
                r_cfg_valid <= 1'b1;
            end
        end
    end

    // Readback word assembled purely from registered state
    always_comb begin
        w_status = '0;
        w_status[STAT_ACK_BIT] = r_ack;
        w_status[STAT_STATE_LSB +: 2] = r_state;
        w_status[STAT_SWAP_LSB +: 8] = r_swap_cnt;
        w_status[STAT_IDX_LSB +: IW] = r_idx;
    end

    assign bus.no_z      = 32'(r_nz);
    assign bus.no_p      = 32'(r_np);
    assign bus.cfg_valid = r_cfg_valid;
    assign bus.status    = w_status;
endmodule

// File: tb/tb_pz_shadow_ctrl.sv
// tb_pz_shadow_ctrl: directed stimulus with a swap scoreboard checked by a separate monitor
module tb_pz_shadow_ctrl;
    localparam int RFS = 16;
    localparam int NPZ = RFS - 1;

    typedef struct {
        logic [31:0] s0;
        logic [31:0] s14;
        logic [7:0]  nz;
        logic [7:0]  np;
        logic [7:0]  sc;
        logic        ack;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    pz_shadow_ctrl_if #(.REG_FILE_SIZE(RFS)) bus ();

    pz_shadow_ctrl #(.REG_FILE_SIZE(RFS)) dut (
        .out_stream_aclk(clk),
        .periph_resetn  (rst_n),
        .bus            (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int i, input logic [31:0] v);
        bus.regfile_flat[i*32 +: 32] = v;
    endtask

    task automatic set_ctrl(input logic t, input logic [7:0] rp, input logic [7:0] rz);
        set_word(NPZ, {t, 15'd0, rp, rz});
    endtask

    task automatic pulse_fs();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic push(input logic [31:0] s0, input logic [7:0] nz, input logic [7:0] np,
                        input logic [7:0] sc, input logic ack);
        exp_t e;
        e.s0 = s0;
        e.s14 = 32'h00EE_0014;
        e.nz = nz;
        e.np = np;
        e.sc = sc;
        e.ack = ack;
        q.push_back(e);
    endtask

    task automatic wait_ready(input string nm);
        int k = 0;
        while (bus.status[17:16] != 2'd2 && k < 40) begin
            tick();
            k++;
        end
        chk(nm, 32'(bus.status[17:16]), 32'd2);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_pz"}, 32'(|bus.pz_flat), 32'd0);
        chk({nm, "_noz"}, bus.no_z, 32'd0);
        chk({nm, "_nop"}, bus.no_p, 32'd0);
        chk({nm, "_valid"}, 32'(bus.cfg_valid), 32'd0);
        chk({nm, "_status"}, bus.status, 32'd0);
    endtask

    // Monitor: every ack toggle is a swap; compare against the oldest queued expectation
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) prev = 1'b0;
            else if (bus.status[31] !== prev) begin
                prev = bus.status[31];
                chk("swap_expected", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("swap_slot0", bus.pz_flat[31:0], e.s0);
                    chk("swap_slot14", bus.pz_flat[14*32 +: 32], e.s14);
                    chk("swap_noz", bus.no_z, 32'(e.nz));
                    chk("swap_nop", bus.no_p, 32'(e.np));
                    chk("swap_valid", 32'(bus.cfg_valid), 32'd1);
                    chk("swap_count", 32'(bus.status[15:8]), 32'(e.sc));
                    chk("swap_ack", 32'(bus.status[31]), 32'(e.ack));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.regfile_flat = '0;
        bus.frame_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("in_reset");
        rst_n = 1'b1;
        tick();
        chk_zero("post_reset");
        pulse_fs();
        tick();
        chk_zero("idle_fs");

        set_word(0, 32'h0010_FFF0);
        set_word(14, 32'h00EE_0014);
        set_ctrl(1'b1, 8'd2, 8'd3);
        tick();
        chk("copy_enter", 32'(bus.status[17:16]), 32'd1);
        chk("copy_idx0", 32'(bus.status[7:0]), 32'd0);
        repeat (14) tick();
        chk("copy_idx14", bus.status[23:0], 24'h01_000E);
        tick();
        chk("ready_enter", 32'(bus.status[17:16]), 32'd2);
        push(32'h0010_FFF0, 8'd3, 8'd2, 8'd1, 1'b1);
        pulse_fs();
        chk("idle_after_swap", 32'(bus.status[17:16]), 32'd0);

        set_word(0, 32'h1234_5678);
        set_ctrl(1'b0, 8'd9, 8'd20);
        tick();
        wait_ready("ready_clamp15");
        push(32'h1234_5678, 8'd15, 8'd0, 8'd2, 1'b0);
        pulse_fs();

        set_word(0, 32'hAAAA_5555);
        set_ctrl(1'b1, 8'd9, 8'd10);
        tick();
        wait_ready("ready_clamp10");
        push(32'hAAAA_5555, 8'd10, 8'd5, 8'd3, 1'b1);
        pulse_fs();

        set_word(0, 32'h0000_0001);
        set_ctrl(1'b0, 8'd1, 8'd1);
        tick();
        repeat (8) tick();
        chk("copy_idx8", 32'(bus.status[7:0]), 32'd8);
        pulse_fs();
        chk("fs_in_copy_state", 32'(bus.status[17:16]), 32'd1);
        chk("fs_in_copy_count", 32'(bus.status[15:8]), 32'd3);
        chk("fs_in_copy_noz", bus.no_z, 32'd10);
        chk("fs_in_copy_slot0", bus.pz_flat[31:0], 32'hAAAA_5555);
        wait_ready("ready_after_ignored");
        push(32'h0000_0001, 8'd1, 8'd1, 8'd4, 1'b0);
        pulse_fs();

        set_word(0, 32'h0BAD_F00D);
        set_ctrl(1'b1, 8'd4, 8'd4);
        tick();
        repeat (7) tick();
        chk("restart_pre_idx7", 32'(bus.status[7:0]), 32'd7);
        set_word(0, 32'h0000_BEEF);
        set_ctrl(1'b0, 8'd4, 8'd4);
        tick();
        chk("restart_idx0", bus.status[23:0], 24'h01_0400);
        repeat (14) tick();
        chk("restart_idx14", bus.status[23:0], 24'h01_040E);
        tick();
        chk("restart_ready", 32'(bus.status[17:16]), 32'd2);
        push(32'h0000_BEEF, 8'd4, 8'd4, 8'd5, 1'b1);
        set_word(0, 32'hCAFE_0000);
        set_ctrl(1'b1, 8'd3, 8'd2);
        pulse_fs();
        chk("swap_commit_state", 32'(bus.status[17:16]), 32'd1);
        chk("swap_commit_idx", 32'(bus.status[7:0]), 32'd0);

        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("rerelease_copy", 32'(bus.status[17:16]), 32'd1);
        wait_ready("rerelease_ready");
        push(32'hCAFE_0000, 8'd2, 8'd3, 8'd1, 1'b1);
        pulse_fs();
        tick();
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
